key_autotype: RTL and testbench



---
 rtl/pet_kbd_pkg.sv | 25 ++
 rtl/key_autotype_if.sv | 11 +
 rtl/kbd_row_merge.sv | 26 ++
 rtl/key_autotype.sv | 103 ++++++++++
 tb/tb_key_autotype.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pet_kbd_pkg.sv
// rtl/pet_kbd_pkg.sv - shared PET keyboard matrix constants, key position type and autotype states
package pet_kbd_pkg;

    localparam int NUM_ROWS  = 10;
    localparam int SHIFT_ROW = 8;
    localparam int SHIFT_COL = 0;

    typedef struct packed {
        logic [3:0] row;
        logic [2:0] col;
    } key_pos_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PRESS = 2'd2,
        ST_GAP   = 2'd3
    } kat_state_t;

    // A zero-length phase still waits for one tick.
    function automatic int eff_ticks(input int n);
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/key_autotype_if.sv
// rtl/key_autotype_if.sv - keystroke request handshake between the loader FIFO and key_autotype
interface key_autotype_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_row;
    logic [2:0] req_col;
    logic       req_shift;

    modport master (output req_valid, req_row, req_col, req_shift, input req_ready);
    modport slave  (input req_valid, req_row, req_col, req_shift, output req_ready);
endinterface

// File: rtl/kbd_row_merge.sv
// rtl/kbd_row_merge.sv - ANDs injected key/shift presses into the live active-low matrix row
module kbd_row_merge
    import pet_kbd_pkg::*;
(
    input  logic [3:0] i_keyrow,
    input  logic [7:0] i_kbd_keyin,
    input  key_pos_t   i_key_pos,
    input  logic       i_key_on,
    input  logic       i_shift_on,
    output logic [7:0] o_keyin
);

    logic [7:0] w_key_mask;
    logic [7:0] w_shift_mask;

    always_comb begin
        w_key_mask   = '0;
        w_shift_mask = '0;
        if (i_key_on && (i_keyrow == i_key_pos.row))
            w_key_mask[i_key_pos.col] = 1'b1;
        if (i_shift_on && (i_keyrow == 4'(SHIFT_ROW)))
            w_shift_mask[SHIFT_COL] = 1'b1;
        o_keyin = i_kbd_keyin & ~(w_key_mask | w_shift_mask);
    end

endmodule

// File: rtl/key_autotype.sv
// rtl/key_autotype.sv - tick-timed press/hold/release sequencer injecting keys into the PET matrix
module key_autotype
    import pet_kbd_pkg::*;
#(
    parameter int SETUP_TICKS = 1,
    parameter int HOLD_TICKS  = 3,
    parameter int GAP_TICKS   = 2,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tick,
    input  logic         abort,
    key_autotype_if.slave req,
    input  logic [3:0]   keyrow,
    input  logic [7:0]   kbd_keyin,
    output logic [7:0]   keyin,
    output logic         busy
);

    localparam logic [CNT_W:0] L_SETUP = (CNT_W+1)'(eff_ticks(SETUP_TICKS));
    localparam logic [CNT_W:0] L_HOLD  = (CNT_W+1)'(eff_ticks(HOLD_TICKS));
    localparam logic [CNT_W:0] L_GAP   = (CNT_W+1)'(eff_ticks(GAP_TICKS));

    kat_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    key_pos_t         r_pos, w_pos_nxt;
    logic             r_shift, w_shift_nxt;
    logic             r_key_on, r_shift_on;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W:0]   w_limit;
    logic             w_accept;

    assign req.req_ready = (r_state == ST_IDLE) && !abort;
    assign w_accept      = req.req_valid && req.req_ready;
    assign busy          = (r_state != ST_IDLE);
    assign w_cnt_inc     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, tick};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_pos;
        w_shift_nxt = r_shift;
        w_limit     = L_GAP;
        case (r_state)
            ST_SETUP: w_limit = L_SETUP;
            ST_PRESS: w_limit = L_HOLD;
            default:  w_limit = L_GAP;
        endcase

        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept) begin
                w_pos_nxt   = '{row: req.req_row, col: req.req_col};
                w_shift_nxt = req.req_shift;
                // Out-of-range rows are swallowed so a bad paste byte cannot stall the FIFO.
                if (req.req_row < 4'(NUM_ROWS)) begin
                    w_state_nxt = req.req_shift ? ST_SETUP : ST_PRESS;
                    w_cnt_nxt   = CNT_W'(tick);
                end
            end
        end else if (w_cnt_inc >= w_limit) begin
            w_cnt_nxt = '0;
            case (r_state)
                ST_SETUP: w_state_nxt = ST_PRESS;
                ST_PRESS: w_state_nxt = ST_GAP;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end else begin
            w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pos      <= '0;
            r_shift    <= 1'b0;
            r_key_on   <= 1'b0;
            r_shift_on <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pos      <= w_pos_nxt;
            r_shift    <= w_shift_nxt;
            r_key_on   <= (w_state_nxt == ST_PRESS);
            r_shift_on <= (w_state_nxt == ST_SETUP) || ((w_state_nxt == ST_PRESS) && w_shift_nxt);
        end
    end

    kbd_row_merge u_merge (
        .i_keyrow    (keyrow),
        .i_kbd_keyin (kbd_keyin),
        .i_key_pos   (r_pos),
        .i_key_on    (r_key_on),
        .i_shift_on  (r_shift_on),
        .o_keyin     (keyin)
    );

endmodule

// File: tb/tb_key_autotype.sv
// tb/tb_key_autotype.sv - randomized self-checking bench for key_autotype against a phase/tick model
module tb_key_autotype;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       abort;
    logic [3:0] keyrow;
    logic [7:0] kbd_keyin;
    logic [7:0] keyin;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_tick = 1'b0;

    always #5 clk = ~clk;

    key_autotype_if u_if ();

    key_autotype #(.SETUP_TICKS(1), .HOLD_TICKS(3), .GAP_TICKS(2), .CNT_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .abort     (abort),
        .req       (u_if),
        .keyrow    (keyrow),
        .kbd_keyin (kbd_keyin),
        .keyin     (keyin),
        .busy      (busy)
    );

    // Model: phase 0 idle, 1 shift-alone, 2 key held, 3 gap; each phase lasts dur[] ticks.
    int         m_phase;
    int         m_seen;
    logic [3:0] m_row;
    logic [2:0] m_col;
    logic       m_shift;
    int         dur [4] = '{0, 1, 3, 2};
    logic [7:0] m_keyin;
    logic       m_ready;
    logic       m_busy;

    always @(posedge clk or negedge reset_n) begin : model
        int n;
        if (!reset_n) begin
            m_phase <= 0; m_seen <= 0; m_row <= 0; m_col <= 0; m_shift <= 0;
        end else if (abort) begin
            m_phase <= 0; m_seen <= 0;
        end else if (m_phase == 0) begin
            if (u_if.req_valid) begin
                m_row <= u_if.req_row; m_col <= u_if.req_col; m_shift <= u_if.req_shift;
                if (u_if.req_row <= 4'd9) begin
                    m_phase <= u_if.req_shift ? 1 : 2;
                    m_seen  <= int'(tick);
                end
            end
        end else begin
            n = m_seen + int'(tick);
            if (n >= dur[m_phase]) begin
                m_phase <= (m_phase == 3) ? 0 : m_phase + 1;
                m_seen  <= 0;
            end else begin
                m_seen <= n;
            end
        end
    end

    always_comb begin
        m_keyin = kbd_keyin;
        if (m_phase == 2 && keyrow == m_row) m_keyin[m_col] = 1'b0;
        if ((m_phase == 1 || (m_phase == 2 && m_shift)) && keyrow == 4'd8) m_keyin[0] = 1'b0;
        m_ready = (m_phase == 0) && !abort;
        m_busy  = (m_phase != 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_tick) tick = ($urandom_range(0, 3) == 0);
        else           tick = (cyc % 10 == 0);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input logic [3:0] row, input logic [2:0] col, input logic sh);
        if (!rand_tick) while (tick) step();
        u_if.req_row = row; u_if.req_col = col; u_if.req_shift = sh; u_if.req_valid = 1'b1;
        settle();
        checks++;
        if (u_if.req_ready !== 1'b1) begin
            errors++; $display("FAIL present_ready got %b want 1", u_if.req_ready);
        end
        step();
        u_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (busy || m_busy); i++) step();
        checks++;
        if (busy !== 1'b0 || m_busy) begin
            errors++; $display("FAIL drain_timeout busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) step();
        kbd_keyin = 8'($urandom); keyrow = 4'd8;
        settle();
        checks++;
        if (keyin !== kbd_keyin) begin errors++; $display("FAIL reset_keyin got %h want %h", keyin, kbd_keyin); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset_n = 1'b1;
        settle();
        checks++;
        if (u_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", u_if.req_ready); end
        kbd_keyin = 8'hFF;
    endtask

    task automatic test_plain_key();
        int low_ticks = 0, gap_ticks = 0;
        keyrow = 4'd4; kbd_keyin = 8'hFF;
        present(4'd4, 3'd0, 1'b0);
        settle();
        checks++;
        if (keyin[0] !== 1'b0) begin errors++; $display("FAIL plain_latency got %b want 0", keyin[0]); end
        for (int i = 0; i < 80 && busy; i++) begin
            checks++;
            if (keyin !== m_keyin) begin errors++; $display("FAIL plain_keyin got %h want %h", keyin, m_keyin); end
            if (tick && !keyin[0]) low_ticks++;
            if (tick && keyin[0]) gap_ticks++;
            step(); settle();
        end
        checks++;
        if (low_ticks != 3) begin errors++; $display("FAIL plain_hold_ticks got %0d want 3", low_ticks); end
        checks++;
        if (gap_ticks != 2) begin errors++; $display("FAIL plain_gap_ticks got %0d want 2", gap_ticks); end
        checks++;
        if (u_if.req_ready !== 1'b1) begin errors++; $display("FAIL plain_ready_after got %b want 1", u_if.req_ready); end
    endtask

    task automatic test_shift_key();
        int alone = 0, both = 0, bad = 0;
        logic s, k;
        kbd_keyin = 8'hFF;
        present(4'd3, 3'd6, 1'b1);
        for (int i = 0; i < 100 && busy; i++) begin
            keyrow = 4'd8; settle(); s = !keyin[0];
            checks++;
            if (keyin !== m_keyin) begin errors++; $display("FAIL shift_row8 got %h want %h", keyin, m_keyin); end
            keyrow = 4'd3; settle(); k = !keyin[6];
            checks++;
            if (keyin !== m_keyin) begin errors++; $display("FAIL shift_row3 got %h want %h", keyin, m_keyin); end
            if (tick && s && !k) alone++;
            if (tick && s && k) both++;
            if (k && !s) bad++;
            step();
        end
        checks++;
        if (alone != 1) begin errors++; $display("FAIL shift_setup_ticks got %0d want 1", alone); end
        checks++;
        if (both != 3) begin errors++; $display("FAIL shift_hold_ticks got %0d want 3", both); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL shift_release_skew got %0d want 0", bad); end
    endtask

    task automatic test_invalid_row();
        kbd_keyin = 8'h5A; keyrow = 4'd10;
        u_if.req_row = 4'd10; u_if.req_col = 3'd2; u_if.req_shift = 1'b1; u_if.req_valid = 1'b1;
        settle();
        checks++;
        if (u_if.req_ready !== 1'b1) begin errors++; $display("FAIL inv_ready got %b want 1", u_if.req_ready); end
        step();
        u_if.req_row = 4'd2; u_if.req_col = 3'd1; u_if.req_shift = 1'b0;
        settle();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL inv_busy got %b want 0", busy); end
        checks++;
        if (keyin !== 8'h5A) begin errors++; $display("FAIL inv_keyin got %h want 5a", keyin); end
        checks++;
        if (u_if.req_ready !== 1'b1) begin errors++; $display("FAIL inv_next_ready got %b want 1", u_if.req_ready); end
        step();
        u_if.req_valid = 1'b0;
        settle();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL inv_next_accept got %b want 1", busy); end
        wait_idle();
    endtask

    task automatic test_abort();
        kbd_keyin = 8'hFF; keyrow = 4'd5;
        present(4'd5, 3'd2, 1'b0);
        for (int i = 0; i < 100 && !(m_phase == 2 && m_seen == 1); i++) step();
        abort = 1'b1;
        u_if.req_row = 4'd2; u_if.req_col = 3'd7; u_if.req_shift = 1'b0; u_if.req_valid = 1'b1;
        settle();
        checks++;
        if (keyin[2] !== 1'b0) begin errors++; $display("FAIL abort_pre_key got %b want 0", keyin[2]); end
        checks++;
        if (u_if.req_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", u_if.req_ready); end
        step();
        abort = 1'b0;
        settle();
        checks++;
        if (keyin !== kbd_keyin) begin errors++; $display("FAIL abort_keyin got %h want %h", keyin, kbd_keyin); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", busy); end
        step();
        u_if.req_valid = 1'b0;
        keyrow = 4'd2;
        settle();
        checks++;
        if (keyin !== 8'h7F) begin errors++; $display("FAIL abort_held_req got %h want 7f", keyin); end
        wait_idle();
    endtask

    task automatic test_merge();
        kbd_keyin = 8'hFE; keyrow = 4'd6;
        present(4'd6, 3'd5, 1'b0);
        settle();
        checks++;
        if (keyin !== 8'hDE) begin errors++; $display("FAIL merge_keyin got %h want de", keyin); end
        wait_idle();
        kbd_keyin = 8'hFF;
    endtask

    task automatic test_async_reset();
        kbd_keyin = 8'hC3; keyrow = 4'd1;
        present(4'd1, 3'd3, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (keyin !== 8'hC3) begin errors++; $display("FAIL areset_keyin got %h want c3", keyin); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
        step();
        reset_n = 1'b1;
        settle();
        checks++;
        if (u_if.req_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b want 1", u_if.req_ready); end
    endtask

    task automatic test_random();
        int issued = 0, accepted = 0;
        logic acc;
        rand_tick = 1'b1;
        for (int i = 0; i < 600; i++) begin
            abort = ($urandom_range(0, 39) == 0);
            if (!u_if.req_valid && $urandom_range(0, 2) == 0) begin
                u_if.req_row = 4'($urandom_range(0, 11)); u_if.req_col = 3'($urandom);
                u_if.req_shift = 1'($urandom); u_if.req_valid = 1'b1; issued++;
            end
            keyrow = ($urandom_range(0, 1) == 0) ? m_row : 4'($urandom_range(0, 9));
            kbd_keyin = 8'($urandom) | 8'($urandom);
            settle();
            checks++;
            if (keyin !== m_keyin) begin errors++; $display("FAIL rand_keyin got %h want %h", keyin, m_keyin); end
            checks++;
            if (busy !== m_busy) begin errors++; $display("FAIL rand_busy got %b want %b", busy, m_busy); end
            checks++;
            if (u_if.req_ready !== m_ready) begin errors++; $display("FAIL rand_ready got %b want %b", u_if.req_ready, m_ready); end
            acc = u_if.req_valid && u_if.req_ready;
            step();
            if (acc) begin u_if.req_valid = 1'b0; accepted++; end
        end
        abort = 1'b0;
        for (int i = 0; i < 300 && u_if.req_valid; i++) begin
            acc = u_if.req_ready;
            step();
            if (acc) begin u_if.req_valid = 1'b0; accepted++; end
        end
        checks++;
        if (accepted != issued) begin errors++; $display("FAIL rand_no_loss got %0d want %0d", accepted, issued); end
        wait_idle();
        rand_tick = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; tick = 1'b0; abort = 1'b0; keyrow = 4'd0; kbd_keyin = 8'hFF;
        u_if.req_valid = 1'b0; u_if.req_row = 4'd0; u_if.req_col = 3'd0; u_if.req_shift = 1'b0;
        test_reset();
        test_plain_key();
        test_shift_key();
        test_invalid_row();
        test_abort();
        test_merge();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
